mcycle_unit: RTL and testbench
==============================

MCYCLE_UNIT -- requirements
Module: mcycle_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have CLK, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 The block SHALL have Reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have Start, input, 1 bit: the decoder requests a multi-cycle operation; it is held high for the whole instruction.
REQ-005 The block SHALL have MCycleOp, input, 2 bits: bit1 selects 0=multiply or 1=divide; bit0 selects 0=signed or 1=unsigned.
REQ-006 The block SHALL have Operand1, input, WIDTH bits: multiplicand or dividend.
REQ-007 The block SHALL have Operand2, input, WIDTH bits: multiplier or divisor.
REQ-008 The block SHALL have Result1, output, WIDTH bits: product low half or quotient.
REQ-009 The block SHALL have Result2, output, WIDTH bits: product high half or remainder.
REQ-010 The block SHALL have Busy, output, 1 bit: stall request to the program counter; the PC holds while Busy=1.

Function
REQ-011 The block SHALL implement the states IDLE, COMPUTE and DONE.
REQ-012 In IDLE with Start=1, the block SHALL drive Busy=1 combinationally in that same cycle, latch Operand1, Operand2 and MCycleOp, clear the iteration count, and go to COMPUTE.
REQ-013 In COMPUTE, the block SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, for exactly WIDTH cycles, with Busy=1.
REQ-014 On the last COMPUTE cycle (count=WIDTH-1), the block SHALL register Result1 and Result2 and go to DONE.
REQ-015 In DONE, the block SHALL drive Busy=0 and go to IDLE next cycle regardless of Start, so that a Start still held by the same instruction does not retrigger.
REQ-016 Busy SHALL be high for exactly WIDTH+1 consecutive cycles per operation, and results SHALL be valid in the DONE cycle.
REQ-017 Signed operations SHALL run on operand magnitudes, and the final result SHALL be negated as required.
REQ-018 Multiply results SHALL form {Result2,Result1} = the full 2*WIDTH-bit product.
REQ-019 Signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-020 Signed MIN/-1 SHALL give quotient 0x80000000 and remainder 0 (wraps, no trap).
REQ-021 Divide by zero, signed or unsigned, SHALL give Result1 all ones and Result2 equal to Operand1, with unchanged latency.
REQ-022 Result1 and Result2 SHALL hold their values until the next DONE.
REQ-023 Operand input changes after the Start cycle SHALL have no effect on the running operation.
REQ-024 Back-to-back operations SHALL work: a Start in the IDLE cycle following DONE begins a new operation.

Reset
REQ-025 While Reset=1, Busy SHALL be 0, the state SHALL be IDLE, Result1 and Result2 SHALL be 0, and the count SHALL be 0.
REQ-026 Reset asserted during COMPUTE SHALL abort the operation without producing any result update.
REQ-027 Reset SHALL take priority over Start in the same cycle.

Configuration
REQ-028 With macro MCYCLE_DIV_EN defined, the block SHALL include divide support as specified above.
REQ-029 Without MCYCLE_DIV_EN, no divider datapath SHALL be present.
REQ-030 Without MCYCLE_DIV_EN, Start with MCycleOp[1]=1 SHALL be ignored: Busy stays 0, state stays IDLE, and results are unchanged.
REQ-031 Multiply behaviour SHALL be identical with and without MCYCLE_DIV_EN.

Verification
REQ-032 Unsigned multiply 0xFFFFFFFF*0xFFFFFFFF -> Busy high 33 cycles, then Result2=0xFFFFFFFE and Result1=0x00000001 in the DONE cycle.
REQ-033 Signed multiply 0xFFFFFFFD*0x00000007 -> Result2=0xFFFFFFFF, Result1=0xFFFFFFEB.
REQ-034 Signed divide 0xFFFFFFF9/0x00000002 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF; unsigned divide 100/0 -> Result1=0xFFFFFFFF, Result2=0x00000064.
REQ-035 Reset pulsed on COMPUTE cycle 10 -> Busy=0 and results=0 the next cycle; a following Start completes normally in 33+1 cycles.
REQ-036 Start held high through DONE and one extra cycle -> exactly one operation, Busy low in DONE, second operation begins only in the following IDLE cycle.
REQ-037 Build without MCYCLE_DIV_EN, Start with MCycleOp=2'b10 -> Busy never asserts and Result1/Result2 keep their prior values.

Source files
------------

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative shift-add multiplier, plus restoring divider when MCYCLE_DIV_EN is defined.
// Busy stalls the PC from the Start cycle through the last step; results are registered for DONE.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_a, r_hi, r_lo;
  logic               r_neg_q;
  logic               w_go, w_last, w_sgn;
  logic [WIDTH-1:0]   w_mag1, w_mag2, w_hi, w_lo, w_res1, w_res2;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul, w_prod;
  assign w_sgn  = !MCycleOp[0];
  assign w_mag1 = (w_sgn && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
  assign w_mag2 = (w_sgn && Operand2[WIDTH-1]) ? -Operand2 : Operand2;
  assign w_last = r_count == CW'(WIDTH - 1);
  assign Busy   = !Reset && (w_go || r_state == COMPUTE);
  // {r_hi, r_lo} is the partial product with the multiplier shifting out of r_lo
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_mul  = {w_sum, r_lo[WIDTH-1:1]};
  assign w_prod = r_neg_q ? -w_mul : w_mul;
`ifdef MCYCLE_DIV_EN
  logic [WIDTH-1:0] r_b, r_op1, w_diff, w_dhi, w_dlo;
  logic             r_div, r_neg_r, w_ok;
  logic [WIDTH:0]   w_sh;
  assign w_go   = Start && r_state == IDLE;
  // divide: r_hi is the partial remainder, r_lo shifts the dividend out and quotient bits in
  assign w_sh   = {r_hi, r_lo[WIDTH-1]};
  assign w_ok   = w_sh >= {1'b0, r_b};
  assign w_diff = w_sh[WIDTH-1:0] - r_b;
  assign w_dhi  = w_ok ? w_diff : w_sh[WIDTH-1:0];
  assign w_dlo  = {r_lo[WIDTH-2:0], w_ok};
  assign w_hi   = r_div ? w_dhi : w_mul[2*WIDTH-1:WIDTH];
  assign w_lo   = r_div ? w_dlo : w_mul[WIDTH-1:0];
  assign w_res1 = !r_div ? w_prod[WIDTH-1:0] : r_b == '0 ? '1 : r_neg_q ? -w_dlo : w_dlo;
  assign w_res2 = !r_div ? w_prod[2*WIDTH-1:WIDTH] : r_b == '0 ? r_op1 : r_neg_r ? -w_dhi : w_dhi;
`else
  assign w_go   = Start && r_state == IDLE && !MCycleOp[1];
  assign w_hi   = w_mul[2*WIDTH-1:WIDTH];
  assign w_lo   = w_mul[WIDTH-1:0];
  assign w_res1 = w_prod[WIDTH-1:0];
  assign w_res2 = w_prod[2*WIDTH-1:WIDTH];
`endif
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= IDLE;
      r_count <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_go) begin
          r_state <= COMPUTE;
          r_count <= '0;
          r_hi    <= '0;
          r_a     <= w_mag1;
          r_neg_q <= w_sgn && (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
`ifdef MCYCLE_DIV_EN
          r_lo    <= MCycleOp[1] ? w_mag1 : w_mag2;
          r_b     <= w_mag2;
          r_op1   <= Operand1;
          r_div   <= MCycleOp[1];
          r_neg_r <= w_sgn && Operand1[WIDTH-1];
`else
          r_lo    <= w_mag2;
`endif
        end
        COMPUTE: begin
          r_hi    <= w_hi;
          r_lo    <= w_lo;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            Result1 <= w_res1;
            Result2 <= w_res2;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: scoreboard bench for mcycle_unit; divide vectors run only when MCYCLE_DIV_EN is defined.
module tb_mcycle_unit;
  localparam int W = 32;
  logic         CLK = 0, Reset = 1, Start = 0;
  logic [1:0]   MCycleOp = 0;
  logic [W-1:0] Operand1 = 0, Operand2 = 0;
  logic [W-1:0] Result1, Result2;
  logic         Busy;
  typedef struct {logic [W-1:0] r1; logic [W-1:0] r2;} exp_t;
  exp_t exp_q[$];
  exp_t e_mon;
  int   total = 0, bad = 0, run_len = 0;
  logic prev_busy = 0;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // monitor: a Busy high->low transition outside reset marks the DONE cycle
  always @(negedge CLK) begin
    #1;
    if (Reset) begin
      run_len = 0;
      prev_busy = 0;
    end else if (Busy) begin
      run_len++;
      prev_busy = 1;
    end else if (prev_busy) begin
      prev_busy = 0;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result %h_%h expected no operation", Result2, Result1);
      end else begin
        e_mon = exp_q.pop_front();
        check("result", {Result2, Result1}, {e_mon.r2, e_mon.r1});
        check("busy_len", 64'(run_len), 64'(W + 1));
      end
      run_len = 0;
    end
  end

  task automatic wait_done();
    int n = 0;
    while (Busy && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (Busy) begin
      total++;
      bad++;
      $display("FAIL timeout: got Busy=1 after %0d cycles expected Busy=0", n);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, b, e1, e2);
    @(negedge CLK);
    Start = 1; MCycleOp = op; Operand1 = a; Operand2 = b;
    exp_q.push_back('{e1, e2});
    @(negedge CLK);
    Operand1 = ~a; Operand2 = b + 3; MCycleOp = op ^ 2'b01;
    wait_done();
    Start = 0; MCycleOp = op;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen;
    repeat (3) @(negedge CLK);
    #1;
    check("reset_busy", Busy, 0);
    check("reset_r1", Result1, 0);
    check("reset_r2", Result2, 0);
    @(negedge CLK);
    Start = 1; MCycleOp = 2'b01; Operand1 = 3; Operand2 = 4;
    #1 check("rst_prio_busy", Busy, 0);
    @(negedge CLK);
    Reset = 0; Start = 0;
    #1 check("rst_prio_idle", Busy, 0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
    run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF);
    run_op(2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000);
    run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    run_op(2'b00, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(2'b00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000);
    // Start held through DONE and into the following IDLE cycle
    @(negedge CLK);
    Start = 1; MCycleOp = 2'b01; Operand1 = 3; Operand2 = 5;
    exp_q.push_back('{32'd15, 32'd0});
    exp_q.push_back('{32'd15, 32'd0});
    @(negedge CLK);
    wait_done();
    @(negedge CLK);
    #1 check("hold_restart", Busy, 1);
    @(negedge CLK);
    wait_done();
    Start = 0;
    // reset on COMPUTE cycle 10
    @(negedge CLK);
    Start = 1; MCycleOp = 2'b00; Operand1 = 7; Operand2 = 9;
    repeat (11) @(negedge CLK);
    Reset = 1;
    #1 check("abort_busy", Busy, 0);
    @(negedge CLK);
    Reset = 0; Start = 0;
    #1;
    check("abort_idle", Busy, 0);
    check("abort_res", {Result2, Result1}, 64'd0);
    run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF);
    run_op(2'b01, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001);
`ifdef MCYCLE_DIV_EN
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_op(2'b11, 32'd100, 32'd0, 32'hFFFFFFFF, 32'h00000064);
    run_op(2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    run_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001);
    run_op(2'b11, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op(2'b11, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0);
`else
    @(negedge CLK);
    Start = 1; MCycleOp = 2'b10; Operand1 = 100; Operand2 = 7;
    busy_seen = 0;
    repeat (40) begin
      #1 if (Busy) busy_seen++;
      @(negedge CLK);
    end
    Start = 0; MCycleOp = 2'b00;
    check("nodiv_busy", 64'(busy_seen), 0);
    #1 check("nodiv_res", {Result2, Result1}, 64'h00000001_23456780);
`endif
    run_op(2'b01, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 32'h00000000);
    repeat (5) @(negedge CLK);
    check("queue_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
